// File: rtl/proc_seq_pkg.sv
// Shared definitions for the byte-serial processor sequencer and its arbiter:
// opcodes, FSM encoding, region layout.
package proc_pkg;

  localparam int MAX_INST  = 28;
  localparam int INST_BASE = 0;
  localparam int OPND_BASE = MAX_INST;
  localparam int RSLT_BASE = 5 * MAX_INST;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_STORE = 2'b10,
    OP_HALT  = 2'b11
  } opcode_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE,
    S_RD0, S_RD1, S_RD2, S_RD3,
    S_WR_REQ, S_WR0, S_WR1, S_WR2, S_WR3,
    S_HALTED
  } state_t;

endpackage

// File: rtl/proc_seq_if.sv
// Sequencer <-> BRAM arbiter request/address/data bundle.
interface proc_seq_if;
  logic       r_inst;
  logic       r_bram;
  logic       r_processor;
  logic [7:0] address_out;
  logic [7:0] p_data_out;
  logic [7:0] p_data_in;

  modport master (output r_inst, r_bram, r_processor, address_out, p_data_out,
                  input  p_data_in);
  modport slave  (input  r_inst, r_bram, r_processor, address_out, p_data_out,
                  output p_data_in);
endinterface

// File: rtl/proc_seq_slot_timer.sv
// Divide-by-4 phase counter; slot_tick marks the clk edge where phase goes 1->2.
module slot_timer (
  input  logic clk,
  input  logic rst_n,
  output logic slot_tick
);
  logic [1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 2'd0;
    else        phase <= phase + 2'd1;
  end

  assign slot_tick = (phase == 2'd1);
endmodule

// File: rtl/proc_seq.sv
// Byte-serial processor sequencer feeding the BRAM arbiter, one step per 4-clk slot.
// Build option: PROC_SAT_EN makes ADD saturate on carry instead of wrapping.
module proc_seq
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  proc_seq_if.master        bus,
  output logic [31:0]       acc,
  output logic [7:0]        pc,
  output logic              done,
  output logic              ovf
);
  // state    | meaning
  // IDLE     | waiting for start
  // FETCH    | r_inst, address = pc
  // DECODE   | r_bram, address = pc, instruction byte captured
  // RD0-RD3  | operand byte k captured, address = idx
  // WR_REQ   | r_processor, address = idx
  // WR0-WR3  | acc byte k on p_data_out
  // HALTED   | done, sticky until reset

  localparam logic [7:0] PC_LAST = 8'(MAX_INST - 1);

  logic        slot_tick;
  state_t      state, state_nx;
  logic [7:0]  inst, inst_nx;
  logic [23:0] opnd, opnd_nx;
  logic [31:0] acc_nx;
  logic [7:0]  pc_nx;
  logic        ovf_nx;
  logic [32:0] sum;
  logic        last;
  logic        r_inst_q, r_bram_q, r_proc_q;
  logic [7:0]  addr_q, pdo_q;
  logic        r_inst_nx, r_bram_nx, r_proc_nx;
  logic [7:0]  addr_nx, pdo_nx;

  slot_timer u_slot_timer (.clk(clk), .rst_n(rst_n), .slot_tick(slot_tick));

  always_comb begin
    state_nx = state;
    inst_nx  = inst;
    opnd_nx  = opnd;
    acc_nx   = acc;
    pc_nx    = pc;
    ovf_nx   = ovf;
    sum      = {1'b0, acc} + {1'b0, bus.p_data_in, opnd};
    last     = (pc == PC_LAST);
    unique case (state)
      S_IDLE:   if (start && !done) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin inst_nx = bus.p_data_in; state_nx = S_RD0; end
      S_RD0:    begin opnd_nx[7:0]   = bus.p_data_in; state_nx = S_RD1; end
      S_RD1:    begin opnd_nx[15:8]  = bus.p_data_in; state_nx = S_RD2; end
      S_RD2:    begin opnd_nx[23:16] = bus.p_data_in; state_nx = S_RD3; end
      S_RD3: begin
        case (opcode_t'(inst[7:6]))
          OP_LOAD, OP_ADD: begin
            if (inst[7:6] == OP_LOAD) begin
              acc_nx = {bus.p_data_in, opnd};
            end else begin
              acc_nx = sum[31:0];
`ifdef PROC_SAT_EN
              if (sum[32]) acc_nx = 32'hFFFF_FFFF;
`endif
              if (sum[32]) ovf_nx = 1'b1;
            end
            // the last instruction slot ends the program rather than wrapping
            if (last) state_nx = S_HALTED;
            else begin pc_nx = pc + 8'd1; state_nx = S_FETCH; end
          end
          OP_STORE: state_nx = S_WR_REQ;
          OP_HALT:  state_nx = S_HALTED;
        endcase
      end
      S_WR_REQ: state_nx = S_WR0;
      S_WR0:    state_nx = S_WR1;
      S_WR1:    state_nx = S_WR2;
      S_WR2:    state_nx = S_WR3;
      S_WR3: begin
        if (last) state_nx = S_HALTED;
        else begin pc_nx = pc + 8'd1; state_nx = S_FETCH; end
      end
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register on the same boundary.
  always_comb begin
    r_inst_nx = (state_nx == S_FETCH);
    r_bram_nx = (state_nx == S_DECODE);
    r_proc_nx = (state_nx == S_WR_REQ);
    addr_nx   = 8'd0;
    pdo_nx    = 8'd0;
    case (state_nx)
      S_FETCH, S_DECODE:                   addr_nx = pc_nx;
      S_RD0, S_RD1, S_RD2, S_RD3, S_WR_REQ: addr_nx = {2'b00, inst_nx[5:0]};
      S_WR0: begin addr_nx = {2'b00, inst_nx[5:0]}; pdo_nx = acc_nx[7:0];   end
      S_WR1: begin addr_nx = {2'b00, inst_nx[5:0]}; pdo_nx = acc_nx[15:8];  end
      S_WR2: begin addr_nx = {2'b00, inst_nx[5:0]}; pdo_nx = acc_nx[23:16]; end
      S_WR3: begin addr_nx = {2'b00, inst_nx[5:0]}; pdo_nx = acc_nx[31:24]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      inst     <= 8'd0;
      opnd     <= 24'd0;
      acc      <= 32'd0;
      pc       <= 8'd0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      r_inst_q <= 1'b0;
      r_bram_q <= 1'b0;
      r_proc_q <= 1'b0;
      addr_q   <= 8'd0;
      pdo_q    <= 8'd0;
    end else if (slot_tick) begin
      state    <= state_nx;
      inst     <= inst_nx;
      opnd     <= opnd_nx;
      acc      <= acc_nx;
      pc       <= pc_nx;
      ovf      <= ovf_nx;
      done     <= (state_nx == S_HALTED);
      r_inst_q <= r_inst_nx;
      r_bram_q <= r_bram_nx;
      r_proc_q <= r_proc_nx;
      addr_q   <= addr_nx;
      pdo_q    <= pdo_nx;
    end
  end

  assign bus.r_inst      = r_inst_q;
  assign bus.r_bram      = r_bram_q;
  assign bus.r_processor = r_proc_q;
  assign bus.address_out = addr_q;
  assign bus.p_data_out  = pdo_q;
endmodule

// File: tb/tb_proc_seq.sv
// Directed bench for proc_seq: per-slot vector table plus end-of-program and reset sequences.
module tb_proc_seq;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] acc;
  logic [7:0]  pc;
  logic        done, ovf;

  proc_seq_if bus();

  proc_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
                .acc(acc), .pc(pc), .done(done), .ovf(ovf));

  always #5 clk = ~clk;

`ifdef PROC_SAT_EN
  localparam logic [31:0] ADD_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] ADD_EXP = 32'h0000_0010;
`endif

  // Slot bookkeeping: slot 0 is the 2-clk partial slot after reset.
  logic [1:0] ph;
  int         slot;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= 2'd0;
      slot <= 0;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd1) slot <= slot + 1;
    end
  end

  logic [7:0]  imem [256];
  logic [31:0] dmem [64];

  // Arbiter/BRAM stand-in: instruction byte in the r_bram slot, then four operand bytes.
  initial begin
    int k;
    k = 4;
    bus.p_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 4;
        bus.p_data_in = 8'h00;
      end else if (ph == 2'd2) begin
        if (bus.r_bram) begin
          bus.p_data_in = imem[bus.address_out];
          k = 0;
        end else if (k < 4) begin
          bus.p_data_in = dmem[bus.address_out[5:0]][8*k +: 8];
          k++;
        end else begin
          bus.p_data_in = 8'h00;
        end
      end
    end
  end

  int n_inst, n_bram, n_proc, n_excl;
  initial begin
    n_inst = 0; n_bram = 0; n_proc = 0; n_excl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_inst = 0; n_bram = 0; n_proc = 0;
      end else if (ph == 2'd2) begin
        if (bus.r_inst)      n_inst++;
        if (bus.r_bram)      n_bram++;
        if (bus.r_processor) n_proc++;
        if (int'(bus.r_inst) + int'(bus.r_bram) + int'(bus.r_processor) > 1) n_excl++;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
    for (int i = 0; i < 64; i++)  dmem[i] = 32'h0;
    case (p)
      0: begin imem[0] = 8'h02; imem[1] = 8'hC0; dmem[2] = 32'h1234_5678; end
      1: begin
        imem[0] = 8'h00; imem[1] = 8'h41; imem[2] = 8'hC0;
        dmem[0] = 32'hFFFF_FFF0; dmem[1] = 32'h0000_0020;
      end
      2: begin
        imem[0] = 8'h03; imem[1] = 8'h85; imem[2] = 8'hC0;
        dmem[3] = 32'hCAFE_BABE; dmem[5] = 32'h1111_1111;
      end
      default: begin
        for (int i = 0; i < MAX_INST; i++) imem[i] = 8'h00;
        dmem[0] = 32'h0000_0055;
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    rst_n = 1'b1;
  endtask

  // Returns at the negedge opening slot n (slot 0: first negedge after release).
  task automatic goto_slot(input int n);
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      budget++;
      if (slot == n && (ph == 2'd2 || n == 0)) break;
      if (budget > 2000) begin
        checks++;
        failures++;
        $display("FAIL slot_wait actual_slot=%0d required_slot=%0d", slot, n);
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] prog, slot, ri, rb, rp, addr, pdo, acc, pc, dn, ov;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] prog, slot, ri, rb, rp, addr, pdo,
                              input logic [31:0] a, p, dn, ov);
    vec_t v;
    v.prog = prog; v.slot = slot; v.ri = ri; v.rb = rb; v.rp = rp;
    v.addr = addr; v.pdo = pdo; v.acc = a; v.pc = p; v.dn = dn; v.ov = ov;
    return v;
  endfunction

  initial begin
    int    cur;
    string pfx;
    //                prog slot ri rb rp addr  pdo   acc            pc dn ov
    vecs.push_back(mk(0,  0,  0, 0, 0, 0,    0,    32'h0,          0, 0, 0));
    vecs.push_back(mk(0,  1,  1, 0, 0, 0,    0,    32'h0,          0, 0, 0));
    vecs.push_back(mk(0,  2,  0, 1, 0, 0,    0,    32'h0,          0, 0, 0));
    vecs.push_back(mk(0,  3,  0, 0, 0, 2,    0,    32'h0,          0, 0, 0));
    vecs.push_back(mk(0,  6,  0, 0, 0, 2,    0,    32'h0,          0, 0, 0));
    vecs.push_back(mk(0,  7,  1, 0, 0, 1,    0,    32'h1234_5678,  1, 0, 0));
    vecs.push_back(mk(0,  9,  0, 0, 0, 0,    0,    32'h1234_5678,  1, 0, 0));
    vecs.push_back(mk(0,  12, 0, 0, 0, 0,    0,    32'h1234_5678,  1, 0, 0));
    vecs.push_back(mk(0,  13, 0, 0, 0, 0,    0,    32'h1234_5678,  1, 1, 0));
    vecs.push_back(mk(1,  7,  1, 0, 0, 1,    0,    32'hFFFF_FFF0,  1, 0, 0));
    vecs.push_back(mk(1,  9,  0, 0, 0, 1,    0,    32'hFFFF_FFF0,  1, 0, 0));
    vecs.push_back(mk(1,  13, 1, 0, 0, 2,    0,    ADD_EXP,        2, 0, 1));
    vecs.push_back(mk(1,  19, 0, 0, 0, 0,    0,    ADD_EXP,        2, 1, 1));
    vecs.push_back(mk(2,  7,  1, 0, 0, 1,    0,    32'hCAFE_BABE,  1, 0, 0));
    vecs.push_back(mk(2,  9,  0, 0, 0, 5,    0,    32'hCAFE_BABE,  1, 0, 0));
    vecs.push_back(mk(2,  12, 0, 0, 0, 5,    0,    32'hCAFE_BABE,  1, 0, 0));
    vecs.push_back(mk(2,  13, 0, 0, 1, 5,    0,    32'hCAFE_BABE,  1, 0, 0));
    vecs.push_back(mk(2,  14, 0, 0, 0, 5,    8'hBE, 32'hCAFE_BABE, 1, 0, 0));
    vecs.push_back(mk(2,  15, 0, 0, 0, 5,    8'hBA, 32'hCAFE_BABE, 1, 0, 0));
    vecs.push_back(mk(2,  16, 0, 0, 0, 5,    8'hFE, 32'hCAFE_BABE, 1, 0, 0));
    vecs.push_back(mk(2,  17, 0, 0, 0, 5,    8'hCA, 32'hCAFE_BABE, 1, 0, 0));
    vecs.push_back(mk(2,  18, 1, 0, 0, 2,    0,    32'hCAFE_BABE,  2, 0, 0));
    vecs.push_back(mk(2,  19, 0, 1, 0, 2,    0,    32'hCAFE_BABE,  2, 0, 0));
    vecs.push_back(mk(2,  24, 0, 0, 0, 0,    0,    32'hCAFE_BABE,  2, 1, 0));

    cur = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (int'(vecs[i].prog) != cur) begin
        cur = int'(vecs[i].prog);
        load_prog(cur);
        do_reset();
      end
      goto_slot(int'(vecs[i].slot));
      pfx = $sformatf("p%0d_s%0d", cur, vecs[i].slot);
      chk({pfx, "_r_inst"},      32'(bus.r_inst),      vecs[i].ri);
      chk({pfx, "_r_bram"},      32'(bus.r_bram),      vecs[i].rb);
      chk({pfx, "_r_processor"}, 32'(bus.r_processor), vecs[i].rp);
      chk({pfx, "_address"},     32'(bus.address_out), vecs[i].addr);
      chk({pfx, "_p_data_out"},  32'(bus.p_data_out),  vecs[i].pdo);
      chk({pfx, "_acc"},         acc,                  vecs[i].acc);
      chk({pfx, "_pc"},          32'(pc),              vecs[i].pc);
      chk({pfx, "_done"},        32'(done),            vecs[i].dn);
      chk({pfx, "_ovf"},         32'(ovf),             vecs[i].ov);
    end

    // Request pulse counts: one r_inst and one r_bram per instruction.
    load_prog(0);
    do_reset();
    goto_slot(20);
    chk("load_n_inst", 32'(n_inst), 2);
    chk("load_n_bram", 32'(n_bram), 2);
    chk("load_n_proc", 32'(n_proc), 0);
    chk("load_done_held", 32'(done), 1);

    load_prog(2);
    do_reset();
    goto_slot(30);
    chk("store_n_inst", 32'(n_inst), 3);
    chk("store_n_bram", 32'(n_bram), 3);
    chk("store_n_proc", 32'(n_proc), 1);

    // End of program without HALT: last instruction fetched in slot 163.
    load_prog(3);
    do_reset();
    goto_slot(163);
    chk("eop_last_fetch_r_inst", 32'(bus.r_inst), 1);
    chk("eop_last_fetch_pc",     32'(pc), 27);
    goto_slot(168);
    chk("eop_rd3_done", 32'(done), 0);
    goto_slot(169);
    chk("eop_done", 32'(done), 1);
    chk("eop_pc",   32'(pc), 27);
    chk("eop_acc",  acc, 32'h55);
    goto_slot(200);
    chk("eop_n_inst",    32'(n_inst), 28);
    chk("eop_n_bram",    32'(n_bram), 28);
    chk("eop_r_inst",    32'(bus.r_inst), 0);
    chk("eop_pc_nowrap", 32'(pc), 27);

    // Reset in the middle of WR1.
    load_prog(2);
    do_reset();
    goto_slot(15);
    chk("rst_pre_pdo", 32'(bus.p_data_out), 8'hBA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_r_inst",      32'(bus.r_inst), 0);
    chk("rst_r_bram",      32'(bus.r_bram), 0);
    chk("rst_r_processor", 32'(bus.r_processor), 0);
    chk("rst_address",     32'(bus.address_out), 0);
    chk("rst_p_data_out",  32'(bus.p_data_out), 0);
    chk("rst_acc",         acc, 0);
    chk("rst_pc",          32'(pc), 0);
    chk("rst_done",        32'(done), 0);
    chk("rst_ovf",         32'(ovf), 0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    rst_n = 1'b1;
    goto_slot(0);
    chk("rst_slot0_r_inst", 32'(bus.r_inst), 0);
    goto_slot(1);
    chk("rst_slot1_r_inst",  32'(bus.r_inst), 1);
    chk("rst_slot1_pc",      32'(pc), 0);
    chk("rst_slot1_address", 32'(bus.address_out), 0);

    chk("request_exclusive", 32'(n_excl), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_seq.md
# proc_seq

Byte-serial processor sequencer sitting directly upstream of the BRAM interface arbiter. Fetches 8-bit instructions, reads 32-bit operands as four byte slots, and writes 32-bit results as four byte slots, driving the arbiter's `r_inst` / `r_bram` / `r_processor` request lines and its address and write-data inputs. Holds a 32-bit accumulator. Runs one step per 4-clk slot, phase-locked to the arbiter's divide-by-4.

## Interface
- `MAX_INST`, 28: instruction-region size in bytes. The program counter runs 0..MAX_INST-1.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: run request, level-sampled at slot boundaries.
- `p_data_in` input 8: instruction/operand byte returned by the arbiter.
- `r_inst` output 1: fetch request.
- `r_bram` output 1: operand-read request.
- `r_processor` output 1: result-write request.
- `address_out` output 8: to the arbiter's `address_in`. Carries the PC during fetch and the operand index otherwise.
- `p_data_out` output 8: write byte to the arbiter's `p_data_in`.
- `acc` output 32: accumulator.
- `pc` output 8: program counter.
- `done` output 1: program finished (sticky).
- `ovf` output 1: sticky ADD overflow flag.

## Operation
- **Instruction byte:**
  - `[7:6]` opcode: 00 LOAD (acc = M[idx]), 01 ADD (acc += M[idx]), 10 STORE (W[idx] = acc), 11 HALT.
  - `[5:0]` = idx.
- **Byte order:** operands and results are little-endian. Slot k carries byte k, bits `[8k+7:8k]`.
- **FSM states:** IDLE, FETCH, DECODE, RD0–RD3, WR_REQ, WR0–WR3, HALTED.
- **Transitions and outputs (one transition per slot):**
  - IDLE → FETCH when `start` = 1 and `done` = 0.
  - FETCH: `r_inst` = 1, `address_out` = pc.
  - DECODE: `r_bram` = 1, `address_out` = pc. The instruction byte is captured at the end of the slot.
  - RD0–RD3: `address_out` = idx. Byte k is captured at the end of RDk.
  - RD3 then branches:
    - LOAD/ADD: update acc, pc += 1, go to FETCH.
    - STORE: discard the read data, go to WR_REQ.
    - HALT: go to HALTED.
  - WR_REQ: `r_processor` = 1, `address_out` = idx.
  - WR0–WR3: `address_out` = idx, `p_data_out` = acc byte k. WR3 → FETCH with pc += 1.
- **Why every instruction does the 4-slot read:** the arbiter leaves its fetch state only on `r_bram`, so every instruction, including STORE and HALT, performs the 4-slot operand read.
- **Request width:** each request line is high for exactly one slot. At most one request line is high in any slot.
- **ADD:** 33-bit sum. The carry sets `ovf` (sticky until reset).
- **End of program:** if pc = MAX_INST-1 completes without HALT, go to HALTED and do not wrap. HALTED sets `done` = 1, holds acc, and ignores `start` until reset.
- **Reset values:** all outputs 0, FSM in IDLE, acc = 0, pc = 0.
- **Reset mid-operation:** reset aborts immediately with no completion of a partial write. The arbiter resets together with this block.

## Timing
- **Phase counter:** 2-bit, resets to 0, increments every clk. The slot boundary is the clk edge where phase goes 1→2 (the same edge the arbiter's state advances).
- **Outputs:** all registered and updated only at slot boundaries, so each value is stable for 4 clk.
- **Data capture:** `p_data_in` is sampled at the closing boundary of its slot.
- **First slot:** the partial slot after reset (2 clk) is idle. The earliest FETCH is slot 1, if `start` is seen at boundary 1.
- **Latency:**
  - LOAD/ADD/HALT: 6 slots (24 clk) from FETCH to the next FETCH.
  - STORE: 11 slots (44 clk).
  - acc updates at the RD3 boundary.

## Configuration
- `PROC_SAT_EN`
  - Defined: ADD saturates to 32'hFFFFFFFF on carry, and still sets `ovf`.
  - Undefined: ADD wraps modulo 2^32 and sets `ovf`.

## Structure
- **Shared package `proc_pkg`:**
  - Opcode constants, the FSM state encoding, and `MAX_INST`.
  - Region base offsets: instructions at 0, operands at MAX_INST, results at 5·MAX_INST.
- **Sub-module `slot_timer`:** phase counter producing the one-cycle `slot_tick` strobe. The arbiter can reuse it.

## Test plan
- **LOAD:** program [LOAD 2, HALT]; M[2] bytes 78,56,34,12.
  - Required: acc = 0x12345678 at the RD3 boundary; `done` = 1 in slot 13.
  - Required: exactly one `r_inst` and one `r_bram` pulse per instruction.
- **ADD overflow:** LOAD 0 (0xFFFFFFF0), ADD 1 (0x20), HALT.
  - Required without `PROC_SAT_EN`: acc = 0x10, `ovf` = 1.
  - Required with `PROC_SAT_EN`: acc = 0xFFFFFFFF, `ovf` = 1.
- **STORE:** LOAD 3 (0xCAFEBABE), STORE 5, HALT.
  - Required: `r_processor` high one slot with address 5; `p_data_out` = BE, BA, FE, CA in WR0–WR3; next FETCH pc = 2.
- **End of program:** 28 LOAD 0 instructions with no HALT.
  - Required: `done` = 1 after pc 27, with no wrap to pc 0.
  - Required: `start` held high afterwards causes no further requests.
- **Reset mid-operation:** assert `rst_n` low during WR1.
  - Required: all outputs 0 immediately and acc = 0; after release with `start` high, the first FETCH is at pc 0 in slot 1.
